// File: rtl/reservation_station.sv
// reservation_station
//   Buffers non-memory instructions until both source operands are known,
//   then issues the lowest-index ready entry to the ALU, one per cycle.
//   Operands are woken by snooping the ALU and LSB result broadcasts.
//
// Ports
//   clk, rst (async, active-low), rdy (global stall when low)
//   dispatch_rs_en, dis_opcode, dis_rob_id, Vi/Vj, Qi/Qj, Oi/Oj,
//     imm_from_dpc, once_pc_from_dpc     : dispatch write
//   is_ok, val_from_alu, rob_id_from_alu : ALU result broadcast
//   lsb_ok, val_from_lsb, rob_id_from_lsb: LSB result broadcast
//   is_clear                             : flush from ROB
//   rs_full                              : at most one free entry left
//   alu_en, alu_opcode, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id
//                                        : registered issue to ALU
module reservation_station #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        dispatch_rs_en,
    input  logic [5:0]  dis_opcode,
    input  logic [3:0]  dis_rob_id,
    input  logic [31:0] Vi,
    input  logic [31:0] Vj,
    input  logic [3:0]  Qi,
    input  logic [3:0]  Qj,
    input  logic        Oi,
    input  logic        Oj,
    input  logic [31:0] imm_from_dpc,
    input  logic [31:0] once_pc_from_dpc,
    input  logic        is_ok,
    input  logic [31:0] val_from_alu,
    input  logic [3:0]  rob_id_from_alu,
    input  logic        lsb_ok,
    input  logic [31:0] val_from_lsb,
    input  logic [3:0]  rob_id_from_lsb,
    input  logic        is_clear,
    output logic        rs_full,
    output logic        alu_en,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_v1,
    output logic [31:0] alu_v2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [3:0]  alu_rob_id
);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ent_o1;
    logic [RS_SIZE-1:0] ent_o2;
    logic [5:0]         ent_op  [RS_SIZE];
    logic [3:0]         ent_rob [RS_SIZE];
    logic [31:0]        ent_v1  [RS_SIZE];
    logic [31:0]        ent_v2  [RS_SIZE];
    logic [3:0]         ent_q1  [RS_SIZE];
    logic [3:0]         ent_q2  [RS_SIZE];
    logic [31:0]        ent_imm [RS_SIZE];
    logic [31:0]        ent_pc  [RS_SIZE];

    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_SIZE-1:0]  free_vec;
    logic                has_issue;
    logic                has_slot;
    logic [RS_IDX_W-1:0] issue_idx;
    logic [RS_IDX_W-1:0] slot_idx;
    logic                do_issue;
    logic                do_dispatch;
    logic [RS_IDX_W:0]   busy_cnt;
    logic                dis_o1;
    logic                dis_o2;
    logic [31:0]         dis_v1;
    logic [31:0]         dis_v2;

    always_comb begin
        ready_vec = busy & ent_o1 & ent_o2;
        has_issue = 1'b0;
        issue_idx = '0;
        for (int unsigned k = RS_SIZE; k > 0; k--) begin
            if (ready_vec[k-1]) begin
                has_issue = 1'b1;
                issue_idx = RS_IDX_W'(k - 1);
            end
        end
        do_issue = rdy && !is_clear && has_issue;

        // The entry issuing this cycle is already reusable by a dispatch.
        free_vec = ~busy;
        if (do_issue) free_vec[issue_idx] = 1'b1;
        has_slot = 1'b0;
        slot_idx = '0;
        for (int unsigned k = RS_SIZE; k > 0; k--) begin
            if (free_vec[k-1]) begin
                has_slot = 1'b1;
                slot_idx = RS_IDX_W'(k - 1);
            end
        end
        do_dispatch = rdy && dispatch_rs_en && !is_clear && has_slot;

        busy_cnt = '0;
        for (int unsigned k = 0; k < RS_SIZE; k++) begin
            busy_cnt = busy_cnt + (RS_IDX_W + 1)'(busy[k]);
        end

        // Same-cycle broadcast bypass for incoming operands.
        dis_o1 = Oi;
        dis_v1 = Vi;
        if (!Oi) begin
            if (is_ok && Qi == rob_id_from_alu) begin
                dis_o1 = 1'b1;
                dis_v1 = val_from_alu;
            end else if (lsb_ok && Qi == rob_id_from_lsb) begin
                dis_o1 = 1'b1;
                dis_v1 = val_from_lsb;
            end
        end
        dis_o2 = Oj;
        dis_v2 = Vj;
        if (!Oj) begin
            if (is_ok && Qj == rob_id_from_alu) begin
                dis_o2 = 1'b1;
                dis_v2 = val_from_alu;
            end else if (lsb_ok && Qj == rob_id_from_lsb) begin
                dis_o2 = 1'b1;
                dis_v2 = val_from_lsb;
            end
        end
    end

    assign rs_full = busy_cnt >= (RS_IDX_W + 1)'(RS_SIZE - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            ent_o1     <= '0;
            ent_o2     <= '0;
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_v1     <= '0;
            alu_v2     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_rob_id <= '0;
            for (int unsigned k = 0; k < RS_SIZE; k++) begin
                ent_op[k]  <= '0;
                ent_rob[k] <= '0;
                ent_v1[k]  <= '0;
                ent_v2[k]  <= '0;
                ent_q1[k]  <= '0;
                ent_q2[k]  <= '0;
                ent_imm[k] <= '0;
                ent_pc[k]  <= '0;
            end
        end else if (rdy) begin
            if (is_clear) begin
                busy   <= '0;
                alu_en <= 1'b0;
            end else begin
                for (int unsigned k = 0; k < RS_SIZE; k++) begin
                    if (busy[k] && !ent_o1[k]) begin
                        if (is_ok && ent_q1[k] == rob_id_from_alu) begin
                            ent_o1[k] <= 1'b1;
                            ent_v1[k] <= val_from_alu;
                        end else if (lsb_ok && ent_q1[k] == rob_id_from_lsb) begin
                            ent_o1[k] <= 1'b1;
                            ent_v1[k] <= val_from_lsb;
                        end
                    end
                    if (busy[k] && !ent_o2[k]) begin
                        if (is_ok && ent_q2[k] == rob_id_from_alu) begin
                            ent_o2[k] <= 1'b1;
                            ent_v2[k] <= val_from_alu;
                        end else if (lsb_ok && ent_q2[k] == rob_id_from_lsb) begin
                            ent_o2[k] <= 1'b1;
                            ent_v2[k] <= val_from_lsb;
                        end
                    end
                end

                alu_en <= do_issue;
                if (do_issue) begin
                    alu_opcode      <= ent_op[issue_idx];
                    alu_v1          <= ent_v1[issue_idx];
                    alu_v2          <= ent_v2[issue_idx];
                    alu_imm         <= ent_imm[issue_idx];
                    alu_pc          <= ent_pc[issue_idx];
                    alu_rob_id      <= ent_rob[issue_idx];
                    busy[issue_idx] <= 1'b0;
                end

                // Placed last so a write into the entry just freed wins.
                if (do_dispatch) begin
                    busy[slot_idx]    <= 1'b1;
                    ent_op[slot_idx]  <= dis_opcode;
                    ent_rob[slot_idx] <= dis_rob_id;
                    ent_o1[slot_idx]  <= dis_o1;
                    ent_o2[slot_idx]  <= dis_o2;
                    ent_v1[slot_idx]  <= dis_v1;
                    ent_v2[slot_idx]  <= dis_v2;
                    ent_q1[slot_idx]  <= Qi;
                    ent_q2[slot_idx]  <= Qj;
                    ent_imm[slot_idx] <= imm_from_dpc;
                    ent_pc[slot_idx]  <= once_pc_from_dpc;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    localparam int RS = 8;

    logic        clk = 1'b0;
    logic        rst, rdy, dispatch_rs_en;
    logic [5:0]  dis_opcode;
    logic [3:0]  dis_rob_id, Qi, Qj, rob_id_from_alu, rob_id_from_lsb;
    logic [31:0] Vi, Vj, imm_from_dpc, once_pc_from_dpc, val_from_alu, val_from_lsb;
    logic        Oi, Oj, is_ok, lsb_ok, is_clear;
    logic        rs_full, alu_en;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_id;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(RS), .RS_IDX_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dispatch_rs_en(dispatch_rs_en), .dis_opcode(dis_opcode), .dis_rob_id(dis_rob_id),
        .Vi(Vi), .Vj(Vj), .Qi(Qi), .Qj(Qj), .Oi(Oi), .Oj(Oj),
        .imm_from_dpc(imm_from_dpc), .once_pc_from_dpc(once_pc_from_dpc),
        .is_ok(is_ok), .val_from_alu(val_from_alu), .rob_id_from_alu(rob_id_from_alu),
        .lsb_ok(lsb_ok), .val_from_lsb(val_from_lsb), .rob_id_from_lsb(rob_id_from_lsb),
        .is_clear(is_clear), .rs_full(rs_full),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: a pool of waiting instructions plus the issue register.
    typedef struct {
        bit        used;
        bit [5:0]  op;
        bit [3:0]  rob;
        bit [31:0] v1, v2;
        bit [3:0]  q1, q2;
        bit        o1, o2;
        bit [31:0] imm, pc;
    } ent_t;

    ent_t      m[RS];
    bit        m_en;
    bit [5:0]  m_op;
    bit [31:0] m_v1, m_v2, m_imm, m_pc;
    bit [3:0]  m_rob;

    function automatic int m_count();
        int c = 0;
        foreach (m[i]) if (m[i].used) c++;
        return c;
    endfunction

    function automatic bit hit(input bit [3:0] q, output bit [31:0] v);
        v = '0;
        if (is_ok && q == rob_id_from_alu) begin v = val_from_alu; return 1'b1; end
        if (lsb_ok && q == rob_id_from_lsb) begin v = val_from_lsb; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        foreach (m[i]) m[i].used = 1'b0;
        m_en = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
    endtask

    task automatic model_step();
        ent_t      nx[RS];
        int        sel;
        int        slot;
        bit [31:0] bv;
        if (!rdy) return;
        if (is_clear) begin
            foreach (m[i]) m[i].used = 1'b0;
            m_en = 1'b0;
            return;
        end
        nx  = m;
        sel = -1;
        foreach (m[i]) if (sel < 0 && m[i].used && m[i].o1 && m[i].o2) sel = i;
        foreach (nx[i]) if (nx[i].used) begin
            if (!nx[i].o1 && hit(nx[i].q1, bv)) begin nx[i].o1 = 1; nx[i].v1 = bv; end
            if (!nx[i].o2 && hit(nx[i].q2, bv)) begin nx[i].o2 = 1; nx[i].v2 = bv; end
        end
        m_en = (sel >= 0);
        if (sel >= 0) begin
            m_op = m[sel].op; m_v1 = m[sel].v1; m_v2 = m[sel].v2;
            m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
            nx[sel].used = 1'b0;
        end
        if (dispatch_rs_en) begin
            slot = -1;
            foreach (nx[i]) if (slot < 0 && !nx[i].used) slot = i;
            if (slot >= 0) begin
                nx[slot].used = 1; nx[slot].op = dis_opcode; nx[slot].rob = dis_rob_id;
                nx[slot].q1 = Qi; nx[slot].q2 = Qj; nx[slot].imm = imm_from_dpc; nx[slot].pc = once_pc_from_dpc;
                if (!Oi && hit(Qi, bv)) begin nx[slot].o1 = 1; nx[slot].v1 = bv; end
                else begin nx[slot].o1 = Oi; nx[slot].v1 = Vi; end
                if (!Oj && hit(Qj, bv)) begin nx[slot].o2 = 1; nx[slot].v2 = bv; end
                else begin nx[slot].o2 = Oj; nx[slot].v2 = Vj; end
            end
        end
        m = nx;
    endtask

    task automatic tick();
        check("rs_full", rs_full, m_count() >= RS - 1);
        model_step();
        @(posedge clk);
        #1;
        check("alu_en", alu_en, m_en);
        check("alu_opcode", alu_opcode, m_op);
        check("alu_v1", alu_v1, m_v1);
        check("alu_v2", alu_v2, m_v2);
        check("alu_imm", alu_imm, m_imm);
        check("alu_pc", alu_pc, m_pc);
        check("alu_rob_id", alu_rob_id, m_rob);
    endtask

    task automatic idle();
        rdy = 1; dispatch_rs_en = 0; is_ok = 0; lsb_ok = 0; is_clear = 0;
    endtask

    task automatic disp(input bit [5:0] op, input bit [3:0] rob,
                        input bit oi, input bit [31:0] vi, input bit [3:0] qi,
                        input bit oj, input bit [31:0] vj, input bit [3:0] qj);
        dispatch_rs_en = 1; dis_opcode = op; dis_rob_id = rob;
        Oi = oi; Vi = vi; Qi = qi; Oj = oj; Vj = vj; Qj = qj;
        imm_from_dpc = $urandom; once_pc_from_dpc = $urandom;
    endtask

    initial begin
        rst = 0;
        idle();
        dis_opcode = 0; dis_rob_id = 0; Vi = 0; Vj = 0; Qi = 0; Qj = 0; Oi = 0; Oj = 0;
        imm_from_dpc = 0; once_pc_from_dpc = 0;
        val_from_alu = 0; rob_id_from_alu = 0; val_from_lsb = 0; rob_id_from_lsb = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_v1", alu_v1, 0);
        check("rst_alu_rob", alu_rob_id, 0);
        check("rst_rs_full", rs_full, 0);
        rst = 1;

        // ready dispatch: issue visible two edges after the write
        idle(); disp(5, 3, 1, 10, 0, 1, 20, 0);
        tick(); idle();
        check("rd_early", alu_en, 0);
        tick();
        check("rd_en", alu_en, 1);
        check("rd_v1", alu_v1, 10);
        check("rd_v2", alu_v2, 20);
        check("rd_rob", alu_rob_id, 3);
        tick();
        check("rd_off", alu_en, 0);

        // ALU wakeup
        idle(); disp(6, 4, 0, 0, 2, 1, 7, 0);
        tick(); idle();
        is_ok = 1; rob_id_from_alu = 2; val_from_alu = 32'hDEAD;
        tick(); idle();
        check("wk_pre", alu_en, 0);
        tick();
        check("wk_en", alu_en, 1);
        check("wk_v1", alu_v1, 32'hDEAD);
        check("wk_rob", alu_rob_id, 4);
        tick();

        // LSB bypass at dispatch
        idle(); disp(7, 5, 1, 1, 0, 0, 0, 7);
        lsb_ok = 1; rob_id_from_lsb = 7; val_from_lsb = 32'h55;
        tick(); idle(); tick();
        check("byp_en", alu_en, 1);
        check("byp_v2", alu_v2, 32'h55);
        check("byp_rob", alu_rob_id, 5);
        tick();

        // fill 7 blocked entries, then wake entries 5 and 2 together
        for (int i = 0; i < 7; i++) begin
            idle(); disp(1, 4'(i), 0, 0, 4'(8 + i), 1, 0, 0);
            if (i == 6) check("full_6", rs_full, 0);
            tick();
        end
        idle();
        check("full_7", rs_full, 1);
        is_ok = 1; rob_id_from_alu = 10; val_from_alu = 32'hA2;
        lsb_ok = 1; rob_id_from_lsb = 13; val_from_lsb = 32'hB5;
        tick(); idle(); tick();
        check("pri_first", alu_rob_id, 2);
        check("pri_first_v", alu_v1, 32'hA2);
        tick();
        check("pri_second", alu_rob_id, 5);
        check("pri_second_v", alu_v1, 32'hB5);

        // clear with same-cycle dispatch
        idle(); disp(2, 9, 1, 3, 0, 1, 4, 0); is_clear = 1;
        tick();
        check("clr1_en", alu_en, 0);
        idle(); disp(3, 1, 0, 0, 15, 1, 0, 0); tick();
        idle(); disp(3, 2, 0, 0, 15, 1, 0, 0); tick();
        idle(); disp(3, 3, 1, 33, 0, 1, 0, 0); tick();
        idle(); disp(3, 4, 1, 44, 0, 1, 0, 0); tick();
        check("clr_pre_rob", alu_rob_id, 3);
        idle(); disp(3, 6, 1, 66, 0, 1, 0, 0); is_clear = 1;
        tick();
        check("clr_en", alu_en, 0);
        idle();
        check("clr_full", rs_full, 0);
        repeat (3) begin
            tick();
            check("clr_quiet", alu_en, 0);
        end

        // async reset between edges while alu_en=1
        idle(); disp(4, 11, 1, 1, 0, 1, 2, 0); tick();
        idle(); disp(4, 12, 1, 5, 0, 1, 6, 0); tick();
        idle();
        check("ar_en_before", alu_en, 1);
        #2 rst = 0;
        #1;
        check("ar_en", alu_en, 0);
        check("ar_v1", alu_v1, 0);
        check("ar_full", rs_full, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1;
        repeat (3) begin
            tick();
            check("ar_quiet", alu_en, 0);
        end

        // freeze with rdy=0
        idle(); disp(8, 9, 0, 0, 6, 1, 0, 0); tick();
        idle(); disp(8, 8, 1, 32'h77, 0, 1, 1, 0); tick();
        idle(); tick();
        check("fz_en", alu_en, 1);
        check("fz_rob", alu_rob_id, 8);
        disp(9, 10, 1, 1, 0, 1, 1, 0);
        is_ok = 1; rob_id_from_alu = 6; val_from_alu = 32'h99;
        rdy = 0;
        repeat (3) begin
            tick();
            check("fz_hold_en", alu_en, 1);
            check("fz_hold_rob", alu_rob_id, 8);
        end
        idle(); tick();
        check("fz_after", alu_en, 0);
        idle(); is_ok = 1; rob_id_from_alu = 6; val_from_alu = 32'h99;
        tick(); idle(); tick();
        check("fz_wake_rob", alu_rob_id, 9);
        check("fz_wake_v1", alu_v1, 32'h99);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            is_clear = ($urandom_range(0, 39) == 0);
            if (m_count() < RS && $urandom_range(0, 2) != 0)
                disp(6'($urandom), 4'($urandom), 1'($urandom), $urandom, 4'($urandom),
                     1'($urandom), $urandom, 4'($urandom));
            is_ok = 1'($urandom); rob_id_from_alu = 4'($urandom); val_from_alu = $urandom;
            lsb_ok = 1'($urandom); rob_id_from_lsb = 4'($urandom); val_from_lsb = $urandom;
            if (is_ok && lsb_ok && rob_id_from_alu == rob_id_from_lsb) val_from_lsb = val_from_alu;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds non-memory instructions from the dispatcher until both source operands are available, then issues one ready instruction per cycle to the ALU. It sits between the dispatcher and the ALU. It snoops the ALU and LSB result broadcasts to wake pending operands. A ROB-driven clear flushes it on branch misprediction.

## Interface
Parameters:
- RS_SIZE, 8: number of entries. Must be a power of two, at least 2.
- RS_IDX_W, 3: log2(RS_SIZE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 clears all state immediately.
- rdy  in  1  global ready. When 0, all state holds and no dispatch is accepted.
- dispatch_rs_en  in  1  dispatcher writes an entry this cycle.
- dis_opcode  in  6  operation code.
- dis_rob_id  in  4  destination ROB tag.
- Vi, Vj  in  32 each  operand values; valid when Oi/Oj=1.
- Qi, Qj  in  4 each  producer ROB tags; meaningful when Oi/Oj=0.
- Oi, Oj  in  1 each  operand-ready flags.
- imm_from_dpc  in  32  immediate.
- once_pc_from_dpc  in  32  instruction PC.
- is_ok  in  1  ALU broadcast valid.
- val_from_alu  in  32  ALU broadcast value.
- rob_id_from_alu  in  4  ALU broadcast tag.
- lsb_ok  in  1  LSB broadcast valid.
- val_from_lsb  in  32  LSB broadcast value.
- rob_id_from_lsb  in  4  LSB broadcast tag.
- is_clear  in  1  flush request from ROB.
- rs_full  out  1  free entries ≤ 1; the fetcher stalls issue while this is high.
- alu_en  out  1  registered; an issued instruction is valid this cycle.
- alu_opcode  out  6  registered.
- alu_v1, alu_v2  out  32 each  registered.
- alu_imm, alu_pc  out  32 each  registered.
- alu_rob_id  out  4  registered.

## Operation
Per-entry state: busy, opcode, rob_id, V1, V2, Q1, Q2, O1, O2, imm, pc.

Dispatch write:
- Condition: rdy && dispatch_rs_en && !is_clear.
- Target: the lowest-index non-busy entry; its busy bit is set.
- Incoming operand bypass: if Oi=0, is_ok=1 and Qi==rob_id_from_alu, store V1=val_from_alu and O1=1. The same check is applied against the LSB broadcast, and identically for operand j. The dispatcher already forwards the ALU result; this bypass is redundant for ALU and required for LSB.
- Dispatch with zero free entries: dropped, no state change. This is a protocol error, since rs_full gives one cycle of slack.

Wakeup:
- Each busy entry with O1=0 and a valid broadcast whose tag equals Q1 captures V1 and sets O1=1. The same applies to operand 2.
- Both ALU and LSB broadcasts are checked every cycle. If both match, either value may be taken, because tags are unique.

Select and issue:
- Candidates are entries with busy && O1 && O2, evaluated on the state at the start of the cycle.
- The lowest-index candidate is chosen. Its fields are loaded into the alu_* registers, alu_en is set to 1, and its busy bit is cleared.
- With no candidate, alu_en=0 and the other alu_* registers hold their values.
- Freeing an entry and writing a new dispatch in the same cycle is allowed, including into the entry being freed. A write into the freed entry takes priority.

Clear (rdy && is_clear):
- All busy bits are cleared and alu_en is set to 0 at the next edge.
- A same-cycle dispatch is discarded.
- No issue occurs that cycle.

rs_full:
- Combinational, from the count of busy entries at the start of the cycle.
- High when count ≥ RS_SIZE-1.

## Timing
Reset (rst=0, asynchronous):
- All busy bits = 0.
- alu_en = 0; alu_opcode, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id all 0.
- rs_full = 0.

Latency:
- An entry dispatched ready in cycle N becomes a candidate in cycle N+1. alu_en is asserted in cycle N+2.
- A broadcast in cycle N wakes an entry at the N edge. That entry is a candidate in N+1 and alu_en is asserted in N+2.
- There is no same-cycle issue of an entry being written.

Throughput: at most one issue and one dispatch per cycle.

rdy=0 freezes everything, including alu_en (held, not cleared). The consumer qualifies with rdy.

Reset asserted mid-operation: all state is lost immediately. Nothing issues until a dispatch after rst returns to 1.

## Test plan
- **Ready dispatch:** reset, then dispatch opcode=5, rob=3, Oi=Oj=1, Vi=10, Vj=20. Expect alu_en=1 exactly two cycles later with alu_v1=10, alu_v2=20, alu_rob_id=3; alu_en=0 the cycle after.
- **Wakeup:** dispatch rob=4 with Oi=0, Qi=2. One cycle later, is_ok=1, rob_id_from_alu=2, val=0xDEAD. Expect issue with alu_v1=0xDEAD two cycles after the broadcast. No issue before the broadcast.
- **LSB bypass:** dispatch with Oj=0, Qj=7 while lsb_ok=1, rob_id_from_lsb=7, val=0x55 in the same cycle. Expect issue two cycles later with alu_v2=0x55.
- **Full/priority:** dispatch 7 blocked entries (RS_SIZE=8). Expect rs_full=1. Wake entries 5 and 2 together. Expect entry 2's rob issued first and entry 5's the next cycle.
- **Clear:** fill 4 entries, two of them ready. Assert is_clear alongside a new dispatch. Expect alu_en=0 next cycle, no further issues, and a busy count of 0 (rs_full=0).
- **Async reset and freeze:** assert rst=0 between clock edges while alu_en=1. Expect alu_en=0 immediately. Separately, with rdy=0 for 3 cycles, broadcasts and dispatches are ignored and outputs are held.
